// File: rtl/d8_mem_dma_if.sv
// Bus bundle for the d8 memory DMA: request/status lines plus the
// dumb8 data-memory port (addr/din/w/dout) that the block drives while busy.
interface d8_mem_dma_if;
   logic       start;
   logic       mode;
   logic [7:0] src;
   logic [7:0] dst;
   logic [7:0] len;
   logic [7:0] fill_val;
   logic       abort;
   logic       busy;
   logic       done;
   logic [7:0] xfer;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic       mem_w;
   logic [7:0] mem_dout;

   // DMA engine side
   modport slave (
      input  start, mode, src, dst, len, fill_val, abort, mem_dout,
      output busy, done, xfer, mem_addr, mem_din, mem_w
   );

   // Requester plus memory side
   modport master (
      output start, mode, src, dst, len, fill_val, abort, mem_dout,
      input  busy, done, xfer, mem_addr, mem_din, mem_w
   );
endinterface

// File: rtl/d8_mem_dma.sv
// Block-copy / block-fill initiator for the 8-bit dumb8 data memory.
// Copy alternates READ (sample combinational dout) and WRITE cycles;
// fill streams WRITE cycles. Addresses wrap mod 256, ascending order.
module d8_mem_dma (
   input logic         sys_clk,
   input logic         sys_rst,
   d8_mem_dma_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t     state;
   logic       mode_r;
   logic [7:0] src_r;
   logic [7:0] dst_r;
   logic [7:0] len_r;
   logic [7:0] fill_r;
   logic [7:0] data_r;
   logic [7:0] idx;
   logic [7:0] xfer_r;

   // Transfer sequencer: latches the request in IDLE, walks idx over the region
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state  <= IDLE;
         mode_r <= 1'b0;
         src_r  <= 8'h00;
         dst_r  <= 8'h00;
         len_r  <= 8'h00;
         fill_r <= 8'h00;
         data_r <= 8'h00;
         idx    <= 8'h00;
         xfer_r <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               // start beats a simultaneous abort simply because abort is not looked at here
               if (bus.start) begin
                  mode_r <= bus.mode;
                  src_r  <= bus.src;
                  dst_r  <= bus.dst;
                  len_r  <= bus.len;
                  fill_r <= bus.fill_val;
                  idx    <= 8'h00;
                  xfer_r <= 8'h00;
                  if (bus.len == 8'h00)
                     state <= DONE;
                  else if (bus.mode)
                     state <= WRITE;
                  else
                     state <= READ;
               end
            end
            READ: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  data_r <= bus.mem_dout;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               // mem_w is high this cycle, so the byte commits even when aborting
               idx    <= idx + 8'd1;
               xfer_r <= xfer_r + 8'd1;
               if (bus.abort)
                  state <= IDLE;
               else if (idx + 8'd1 == len_r)
                  state <= DONE;
               else if (mode_r)
                  state <= WRITE;
               else
                  state <= READ;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port and status decode straight from state, so reset drops mem_w at once
   always_comb begin
      bus.mem_addr = 8'h00;
      bus.mem_din  = 8'h00;
      bus.mem_w    = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      case (state)
         READ: begin
            bus.mem_addr = src_r + idx;
            bus.busy     = 1'b1;
         end
         WRITE: begin
            bus.mem_addr = dst_r + idx;
            bus.mem_din  = mode_r ? fill_r : data_r;
            bus.mem_w    = 1'b1;
            bus.busy     = 1'b1;
         end
         DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.xfer = xfer_r;

endmodule

// File: tb/tb_d8_mem_dma.sv
// Directed bench for d8_mem_dma: 256-byte combinational-read memory model,
// per-scenario tasks with hand-computed expectations.
module tb_d8_mem_dma;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [7:0] mem [256];
   logic       pl_w = 1'b0;
   logic [7:0] pl_a = 8'h00;
   logic [7:0] pl_d = 8'h00;

   d8_mem_dma_if bus ();

   d8_mem_dma dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // memory model: DMA write port, plus a bench preload port used only while idle
   always @(posedge clk) begin
      if (bus.mem_w)
         mem[bus.mem_addr] <= bus.mem_din;
      else if (pl_w)
         mem[pl_a] <= pl_d;
   end

   assign bus.mem_dout = mem[bus.mem_addr];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      pl_w = 1'b1; pl_a = a; pl_d = d;
      step();
      pl_w = 1'b0;
   endtask

   // drive a one-cycle start; returns at the negedge inside cycle 1
   task automatic go(input logic m, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, input logic [7:0] f);
      bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d;
      bus.len = l; bus.fill_val = f;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.mem_w !== 1'b0) begin n_err++; $display("FAIL reset_mem_w got %b want 0", bus.mem_w); end
      n_cmp++; if (bus.xfer !== 8'h00) begin n_err++; $display("FAIL reset_xfer got %h want 00", bus.xfer); end
      n_cmp++; if (bus.mem_addr !== 8'h00 || bus.mem_din !== 8'h00) begin n_err++; $display("FAIL reset_addr_din got %h/%h want 00/00", bus.mem_addr, bus.mem_din); end
   endtask

   task automatic test_fill();
      logic [7:0] ea;
      go(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         ea = 8'h10 + 8'(k);
         n_cmp++;
         if (bus.mem_w !== 1'b1 || bus.mem_addr !== ea || bus.mem_din !== 8'hA5 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL fill_cycle%0d got w=%b a=%h d=%h busy=%b want w=1 a=%h d=a5 busy=1", k+1, bus.mem_w, bus.mem_addr, bus.mem_din, bus.busy, ea);
         end
      end
      step();
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.mem_w !== 1'b0) begin n_err++; $display("FAIL fill_done got done=%b busy=%b w=%b want 1/0/0", bus.done, bus.busy, bus.mem_w); end
      n_cmp++; if (bus.xfer !== 8'd4) begin n_err++; $display("FAIL fill_xfer got %0d want 4", bus.xfer); end
      step();
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL fill_done_pulse got %b want 0", bus.done); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (mem[8'h10 + k] !== 8'hA5) begin n_err++; $display("FAIL fill_mem[%0d] got %h want a5", k, mem[8'h10 + k]); end
      end
   endtask

   // generic copy trace check: expected addresses alternate read/write, done in cycle 2N+1
   task automatic check_copy(input string nm, input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
      logic [7:0] ea;
      for (int k = 0; k < 2 * int'(l); k++) begin
         if (k > 0) step();
         ea = (k % 2 == 0) ? s + 8'(k / 2) : d + 8'(k / 2);
         n_cmp++;
         if (bus.mem_addr !== ea || bus.mem_w !== 1'(k % 2) || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL %s_cycle%0d got a=%h w=%b busy=%b want a=%h w=%0d busy=1", nm, k+1, bus.mem_addr, bus.mem_w, bus.busy, ea, k % 2);
         end
      end
      step();
      n_cmp++; if (bus.done !== 1'b1 || bus.xfer !== l) begin n_err++; $display("FAIL %s_done got done=%b xfer=%0d want 1/%0d", nm, bus.done, bus.xfer, l); end
      step();
   endtask

   task automatic test_copy();
      poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
      go(1'b0, 8'h20, 8'h40, 8'd3, 8'h00);
      check_copy("copy", 8'h20, 8'h40, 8'd3);
      n_cmp++; if (mem[8'h40] !== 8'h01 || mem[8'h41] !== 8'h02 || mem[8'h42] !== 8'h03) begin n_err++; $display("FAIL copy_mem got %h %h %h want 01 02 03", mem[8'h40], mem[8'h41], mem[8'h42]); end
   endtask

   task automatic test_wrap();
      poke(8'hFE, 8'h7A); poke(8'hFF, 8'h7B); poke(8'h00, 8'h7C);
      go(1'b0, 8'hFE, 8'h00, 8'd3, 8'h00);
      check_copy("wrap", 8'hFE, 8'h00, 8'd3);
      n_cmp++; if (mem[0] !== 8'h7A || mem[1] !== 8'h7B || mem[2] !== 8'h7A) begin n_err++; $display("FAIL wrap_mem got %h %h %h want 7a 7b 7a", mem[0], mem[1], mem[2]); end
   endtask

   task automatic test_len0();
      logic saw_w = 1'b0;
      go(1'b1, 8'h00, 8'h30, 8'd0, 8'h99);
      saw_w = bus.mem_w;
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL len0_done got done=%b busy=%b want 1/0", bus.done, bus.busy); end
      step();
      saw_w = saw_w | bus.mem_w;
      n_cmp++; if (bus.done !== 1'b0 || saw_w !== 1'b0) begin n_err++; $display("FAIL len0_after got done=%b sawW=%b want 0/0", bus.done, saw_w); end
   endtask

   task automatic test_overlap();
      poke(8'h50, 8'h11); poke(8'h51, 8'h22); poke(8'h52, 8'h33); poke(8'h53, 8'h44);
      go(1'b0, 8'h50, 8'h51, 8'd3, 8'h00);
      check_copy("overlap", 8'h50, 8'h51, 8'd3);
      n_cmp++; if (mem[8'h51] !== 8'h11 || mem[8'h52] !== 8'h11 || mem[8'h53] !== 8'h11) begin n_err++; $display("FAIL overlap_mem got %h %h %h want 11 11 11", mem[8'h51], mem[8'h52], mem[8'h53]); end
   endtask

   task automatic test_abort();
      for (int k = 0; k < 8; k++) poke(8'h60 + 8'(k), 8'h00);
      go(1'b1, 8'h00, 8'h60, 8'd8, 8'h5C);
      step();                              // cycle 2: second WRITE
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_w !== 1'b0) begin n_err++; $display("FAIL abort_idle got busy=%b done=%b w=%b want 0/0/0", bus.busy, bus.done, bus.mem_w); end
      n_cmp++; if (bus.xfer !== 8'd2) begin n_err++; $display("FAIL abort_xfer got %0d want 2", bus.xfer); end
      step();
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_nodone got %b want 0", bus.done); end
      n_cmp++; if (mem[8'h60] !== 8'h5C || mem[8'h61] !== 8'h5C || mem[8'h62] !== 8'h00) begin n_err++; $display("FAIL abort_mem got %h %h %h want 5c 5c 00", mem[8'h60], mem[8'h61], mem[8'h62]); end
   endtask

   task automatic test_start_busy();
      poke(8'h80, 8'h00);
      go(1'b0, 8'h20, 8'h70, 8'd3, 8'h00);
      // conflicting request during cycle 2 must be ignored
      step();
      bus.start = 1'b1; bus.mode = 1'b1; bus.dst = 8'h80; bus.len = 8'd1; bus.fill_val = 8'hFF;
      n_cmp++; if (bus.mem_addr !== 8'h70 || bus.mem_w !== 1'b1) begin n_err++; $display("FAIL busy_start_c2 got a=%h w=%b want 70/1", bus.mem_addr, bus.mem_w); end
      step();
      bus.start = 1'b0;
      n_cmp++; if (bus.mem_addr !== 8'h21 || bus.mem_w !== 1'b0) begin n_err++; $display("FAIL busy_start_c3 got a=%h w=%b want 21/0", bus.mem_addr, bus.mem_w); end
      step(); step(); step();              // cycles 4..6
      n_cmp++; if (bus.mem_addr !== 8'h72 || bus.mem_w !== 1'b1) begin n_err++; $display("FAIL busy_start_c6 got a=%h w=%b want 72/1", bus.mem_addr, bus.mem_w); end
      step();
      n_cmp++; if (bus.done !== 1'b1 || bus.xfer !== 8'd3) begin n_err++; $display("FAIL busy_start_done got done=%b xfer=%0d want 1/3", bus.done, bus.xfer); end
      step();
      n_cmp++; if (mem[8'h70] !== 8'h01 || mem[8'h72] !== 8'h03 || mem[8'h80] !== 8'h00) begin n_err++; $display("FAIL busy_start_mem got %h %h %h want 01 03 00", mem[8'h70], mem[8'h72], mem[8'h80]); end
   endtask

   task automatic test_async_reset();
      poke(8'h90, 8'h00); poke(8'h91, 8'h00);
      go(1'b0, 8'h20, 8'h90, 8'd3, 8'h00);
      step(); step(); step();              // cycle 4: second WRITE
      n_cmp++; if (bus.mem_w !== 1'b1 || bus.xfer !== 8'd1) begin n_err++; $display("FAIL areset_pre got w=%b xfer=%0d want 1/1", bus.mem_w, bus.xfer); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.mem_w !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.xfer !== 8'h00) begin n_err++; $display("FAIL areset_now got w=%b busy=%b done=%b xfer=%0d want 0/0/0/0", bus.mem_w, bus.busy, bus.done, bus.xfer); end
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (mem[8'h90] !== 8'h01 || mem[8'h91] !== 8'h00) begin n_err++; $display("FAIL areset_mem got %h %h want 01 00", mem[8'h90], mem[8'h91]); end
      go(1'b1, 8'h00, 8'hA0, 8'd2, 8'h33);
      n_cmp++; if (bus.mem_addr !== 8'hA0 || bus.mem_w !== 1'b1) begin n_err++; $display("FAIL areset_restart got a=%h w=%b want a0/1", bus.mem_addr, bus.mem_w); end
      step(); step();
      n_cmp++; if (bus.done !== 1'b1 || bus.xfer !== 8'd2) begin n_err++; $display("FAIL areset_restart_done got done=%b xfer=%0d want 1/2", bus.done, bus.xfer); end
      step();
      n_cmp++; if (mem[8'hA0] !== 8'h33 || mem[8'hA1] !== 8'h33) begin n_err++; $display("FAIL areset_restart_mem got %h %h want 33 33", mem[8'hA0], mem[8'hA1]); end
   endtask

   initial begin
      bus.start = 1'b0; bus.mode = 1'b0; bus.src = 8'h00; bus.dst = 8'h00;
      bus.len = 8'h00; bus.fill_val = 8'h00; bus.abort = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      @(negedge clk); @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_fill();
      test_copy();
      test_wrap();
      test_len0();
      test_overlap();
      test_abort();
      test_start_busy();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/d8_mem_dma.md
# d8_mem_dma

Block-transfer initiator for the dumb8 8-bit data memory port (addr/din/w/dout). It copies a byte region, or fills one with a constant, by driving the memory's address, write-data and write-enable lines and sampling its combinational read data. It sits beside the core on the data-memory bus. While `busy` is high, it owns the port through an external mux.

## Interface
- No parameters; widths are fixed to the 8-bit dumb8 data space.
- sys_clk  in  1  single clock; all state updates on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; latched with start
- src  in  8  copy source base address; latched with start
- dst  in  8  destination base address; latched with start
- len  in  8  byte count; 0 means no transfer; latched with start
- fill_val  in  8  fill byte; latched with start
- abort  in  1  cancel an active transfer
- busy  out  1  high in READ/WRITE; the bus mux selects this block when high
- done  out  1  one-cycle completion pulse
- xfer  out  8  bytes written so far in the current or last transfer
- mem_addr  out  8  memory address
- mem_din  out  8  memory write data
- mem_w  out  1  memory write enable
- mem_dout  in  8  memory read data; combinational from mem_addr when mem_w=0

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: state, mode_r, src_r, dst_r, len_r, fill_r, data_r, idx (8b), xfer.
- IDLE:
  - mem_w=0, mem_addr=0, mem_din=0, busy=0, done=0.
  - start=1 latches all inputs and clears idx and xfer.
  - Next state: DONE if len=0; otherwise READ for copy, WRITE for fill.
- READ (copy only):
  - mem_addr=src_r+idx, mem_w=0.
  - At the clock edge, data_r <= mem_dout. Next state WRITE.
- WRITE:
  - mem_addr=dst_r+idx, mem_w=1.
  - mem_din=data_r for copy, fill_r for fill.
  - At the edge: idx++ and xfer++.
  - If idx+1 == len_r, next state DONE. Otherwise next state is READ for copy, or stays WRITE for fill.
- DONE: done=1, busy=0, mem_w=0. Next state IDLE.
- mem_addr, mem_din and mem_w are combinational decodes of state and registers.
- Address arithmetic is mod 256. src_r+idx and dst_r+idx wrap 0xFF→0x00 silently.
- Overlapping regions are copied in ascending order, byte-at-a-time. With dst in (src, src+len), earlier written bytes are re-read; this is the defined behaviour, and there is no memmove semantics.
- abort=1 in READ or WRITE:
  - Next state is IDLE, with no done pulse.
  - A WRITE cycle coinciding with abort still commits its byte, because mem_w is high at that edge.
  - xfer counts that byte.
- abort in IDLE or DONE has no effect.
- start outside IDLE is ignored. Inputs are only latched in IDLE.
- Simultaneous start and abort in IDLE: start wins.

## Timing
- Reset (async, immediate): state=IDLE, all registers 0, busy=0, done=0, xfer=0, mem_w=0, mem_addr=0, mem_din=0.
- Reset mid-transfer drops mem_w in the same cycle. Bytes already committed remain in memory.
- Start sampled at edge T0; first memory cycle is T0→T1.
- Copy of N≥1 bytes: busy for 2N cycles; done high in cycle 2N+1 after T0.
- Fill of N≥1 bytes: busy for N cycles; done in cycle N+1.
- len=0: done in cycle 1 after T0; busy never asserts; mem_w never asserts.
- Next start is accepted in the cycle after done, i.e. once back in IDLE.
- The memory presents dout combinationally in the READ cycle. No wait states are supported.

## Test plan
- Fill: mode=1, dst=0x10, len=4, fill_val=0xA5 → mem_w high for 4 consecutive cycles at 0x10..0x13; done after 5 cycles; xfer=4; memory reads 0xA5 ×4.
- Copy: preload 0x20..0x22 = 01,02,03; src=0x20, dst=0x40, len=3 → alternating read/write addresses 20,40,21,41,22,42; done in cycle 7; 0x40..0x42 = 01,02,03.
- Wrap and len=0:
  - Copy src=0xFE, dst=0x00, len=3 reads FE,FF,00 → 0x00 then holds the old 0xFE byte, and the read from 0x00 returns that updated value.
  - len=0 → done one cycle after start, mem_w never high.
- Overlap: 0x50..0x53 = 11,22,33,44; copy src=0x50, dst=0x51, len=3 → 0x51..0x53 = 11,11,11.
- Abort and ignored start:
  - abort on 2nd WRITE of a fill, len=8 → exactly 2 bytes written; xfer=2; no done pulse; IDLE next cycle.
  - start pulsed while busy → parameters unchanged and the transfer completes as originally requested.
- Async reset mid-copy: sys_rst asserted between edges → mem_w, busy, done and xfer are 0 immediately; after release, a fresh start runs normally.
